// File: rtl/bfly02_sdf_butterfly.sv
// ---------------------------------------------------------------------------
// bfly02_sdf_butterfly
//   Radix-2 single-delay-feedback butterfly for the bfly02 FFT stage.
//   A frame is 2*DEPTH beats of NUM_PARALLEL_PATHS complex samples. Beat j of
//   the first half is paired with beat j of the second half. The sum A+B is
//   emitted while the second half streams in. The difference A-B is parked in
//   the delay line and emitted afterwards, either overlapped with the next
//   frame's first half or in a drain phase. Results are LENGTH+1 bits wide and
//   are exact, so no overflow is possible.
//
//   Optional feature macro: BFLY02_OVF_FLAG_EN (adds ovf_flag output).
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous, active-high reset
//   in_valid   input beat present
//   in_ready   block accepts a beat this cycle (low only while draining)
//   in_real    LENGTH x NUM_PARALLEL_PATHS signed input, real part
//   in_imag    LENGTH x NUM_PARALLEL_PATHS signed input, imaginary part
//   out_valid  output beat present (no backpressure)
//   out_last   final difference beat of a frame
//   ovf_flag   (BFLY02_OVF_FLAG_EN only) some result exceeds LENGTH-bit range
//   out_real   (LENGTH+1) x NUM_PARALLEL_PATHS signed result, real part
//   out_imag   (LENGTH+1) x NUM_PARALLEL_PATHS signed result, imaginary part
// ---------------------------------------------------------------------------
module bfly02_sdf_butterfly #(
    parameter int LENGTH             = 13,
    parameter int NUM_PARALLEL_PATHS = 16,
    parameter int DEPTH              = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [LENGTH*NUM_PARALLEL_PATHS-1:0]       in_real,
    input  logic [LENGTH*NUM_PARALLEL_PATHS-1:0]       in_imag,
    output logic                                       out_valid,
    output logic                                       out_last,
`ifdef BFLY02_OVF_FLAG_EN
    output logic                                       ovf_flag,
`endif
    output logic [(LENGTH+1)*NUM_PARALLEL_PATHS-1:0]   out_real,
    output logic [(LENGTH+1)*NUM_PARALLEL_PATHS-1:0]   out_imag
);

    localparam int W1 = LENGTH + 1;
    localparam int NP = NUM_PARALLEL_PATHS;
    localparam int WW = 2 * NP * W1;       // one complex word for all paths
    localparam int CW = $clog2(2 * DEPTH);

    typedef enum logic [2:0] {IDLE, FILL, CALC, OVERLAP, DRAIN} state_t;

    function automatic logic signed [W1-1:0] sext(input logic signed [LENGTH-1:0] x);
        return {x[LENGTH-1], x};
    endfunction

`ifdef BFLY02_OVF_FLAG_EN
    // Outside the LENGTH-bit range exactly when the two top bits disagree.
    function automatic logic out_of_range(input logic signed [W1-1:0] x);
        return x[W1-1] ^ x[W1-2];
    endfunction
`endif

    state_t          state, nstate;
    logic [CW-1:0]   cnt, ncnt;
    logic            pend, npend;      // first cycle after CALC: overlap or drain?

    // Delay line, word layout per path p: re at field 2p, im at field 2p+1.
    logic [WW-1:0]   dl [DEPTH];
    logic [WW-1:0]   head;

    logic [WW-1:0]   ext_p0, sum_p0, dif_p0, res_p0, push_p0;
    logic            acc, shift_p0, vld_p0, last_p0;

    logic [NP*W1-1:0] re_p1, im_p1;
    logic             vld_p1, last_p1;

    assign head     = dl[0];
    assign in_ready = (state != DRAIN);
    assign acc      = in_valid && in_ready;

    // ---- stage 0: sign extension, butterfly, result/push selection --------
    always_comb begin
        ext_p0 = '0;
        sum_p0 = '0;
        dif_p0 = '0;
        for (int p = 0; p < NP; p++) begin
            ext_p0[2*p*W1 +: W1]     = sext(in_real[p*LENGTH +: LENGTH]);
            ext_p0[(2*p+1)*W1 +: W1] = sext(in_imag[p*LENGTH +: LENGTH]);
        end
        for (int f = 0; f < 2*NP; f++) begin
            sum_p0[f*W1 +: W1] = $signed(head[f*W1 +: W1]) + $signed(ext_p0[f*W1 +: W1]);
            dif_p0[f*W1 +: W1] = $signed(head[f*W1 +: W1]) - $signed(ext_p0[f*W1 +: W1]);
        end
    end

    always_comb begin
        nstate   = state;
        ncnt     = cnt;
        npend    = pend;
        shift_p0 = 1'b0;
        vld_p0   = 1'b0;
        last_p0  = 1'b0;
        res_p0   = head;
        push_p0  = ext_p0;
        case (state)
            IDLE: begin
                if (acc) begin
                    shift_p0 = 1'b1;
                    ncnt     = CW'(1);
                    nstate   = (DEPTH == 1) ? CALC : FILL;
                end
            end
            FILL: begin
                if (acc) begin
                    shift_p0 = 1'b1;
                    ncnt     = cnt + CW'(1);
                    if (cnt == CW'(DEPTH-1))
                        nstate = CALC;
                end
            end
            CALC: begin
                if (acc) begin
                    shift_p0 = 1'b1;
                    vld_p0   = 1'b1;
                    res_p0   = sum_p0;
                    push_p0  = dif_p0;
                    if (cnt == CW'(2*DEPTH-1)) begin
                        ncnt   = '0;
                        npend  = 1'b1;
                        nstate = OVERLAP;
                    end else begin
                        ncnt = cnt + CW'(1);
                    end
                end
            end
            OVERLAP: begin
                if (acc) begin
                    shift_p0 = 1'b1;
                    vld_p0   = 1'b1;
                    npend    = 1'b0;
                    if (cnt == CW'(DEPTH-1)) begin
                        last_p0 = 1'b1;
                        ncnt    = CW'(DEPTH);
                        nstate  = CALC;
                    end else begin
                        ncnt = cnt + CW'(1);
                    end
                end else if (pend) begin
                    // No next frame right behind this one: flush differences.
                    npend  = 1'b0;
                    ncnt   = '0;
                    nstate = DRAIN;
                end
            end
            DRAIN: begin
                shift_p0 = 1'b1;
                vld_p0   = 1'b1;
                push_p0  = '0;
                if (cnt == CW'(DEPTH-1)) begin
                    last_p0 = 1'b1;
                    ncnt    = '0;
                    nstate  = IDLE;
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            default: begin
                nstate = IDLE;
                ncnt   = '0;
                npend  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            pend  <= npend;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_p0) begin
            for (int i = 0; i < DEPTH-1; i++)
                dl[i] <= dl[i+1];
            dl[DEPTH-1] <= push_p0;
        end
    end

    // ---- stage 1: registered outputs --------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            re_p1   <= '0;
            im_p1   <= '0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
            if (vld_p0) begin
                for (int p = 0; p < NP; p++) begin
                    re_p1[p*W1 +: W1] <= res_p0[2*p*W1 +: W1];
                    im_p1[p*W1 +: W1] <= res_p0[(2*p+1)*W1 +: W1];
                end
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_last  = last_p1;
    assign out_real  = re_p1;
    assign out_imag  = im_p1;

`ifdef BFLY02_OVF_FLAG_EN
    logic ovf_p0, ovf_p1;

    always_comb begin
        ovf_p0 = 1'b0;
        for (int f = 0; f < 2*NP; f++)
            if (out_of_range(res_p0[f*W1 +: W1]))
                ovf_p0 = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_p1 <= 1'b0;
        else
            ovf_p1 <= vld_p0 && ovf_p0;
    end

    assign ovf_flag = ovf_p1;
`endif

endmodule

// File: tb/tb_bfly02_sdf_butterfly.sv
// ---------------------------------------------------------------------------
// tb_bfly02_sdf_butterfly
//   Directed self-checking bench for bfly02_sdf_butterfly with default
//   parameters (LENGTH=13, 16 paths, DEPTH=16). Expected values are written
//   down from the butterfly arithmetic of each directed frame.
// ---------------------------------------------------------------------------
module tb_bfly02_sdf_butterfly;

    localparam int LENGTH = 13;
    localparam int NP     = 16;
    localparam int DEPTH  = 16;
    localparam int W1     = LENGTH + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [LENGTH*NP-1:0]   in_real;
    logic [LENGTH*NP-1:0]   in_imag;
    logic                   out_valid;
    logic                   out_last;
    logic [W1*NP-1:0]       out_real;
    logic [W1*NP-1:0]       out_imag;
`ifdef BFLY02_OVF_FLAG_EN
    logic                   ovf_flag;
`endif

    bfly02_sdf_butterfly #(
        .LENGTH             (LENGTH),
        .NUM_PARALLEL_PATHS (NP),
        .DEPTH              (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_last  (out_last),
`ifdef BFLY02_OVF_FLAG_EN
        .ovf_flag  (ovf_flag),
`endif
        .out_real  (out_real),
        .out_imag  (out_imag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W1*NP-1:0] re;
        logic [W1*NP-1:0] im;
        logic             last;
        logic             ovf;
        int               cyc;
    } beat_t;

    beat_t oq[$];
    int    cyc     = 0;
    int    rdy_low = 0;
    int    n_cmp   = 0;
    int    n_err   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && !in_ready)
            rdy_low++;
        if (!rst && out_valid) begin
            beat_t bt;
            bt.re   = out_real;
            bt.im   = out_imag;
            bt.last = out_last;
`ifdef BFLY02_OVF_FLAG_EN
            bt.ovf  = ovf_flag;
`else
            bt.ovf  = 1'b0;
`endif
            bt.cyc  = cyc;
            oq.push_back(bt);
        end
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pv(input logic [W1*NP-1:0] v, input int p);
        logic signed [W1-1:0] s;
        s = v[p*W1 +: W1];
        return int'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int re, input int im);
        for (int p = 0; p < NP; p++) begin
            in_real[p*LENGTH +: LENGTH] = LENGTH'(re);
            in_imag[p*LENGTH +: LENGTH] = LENGTH'(im);
        end
    endtask

    // One full frame: first half A, second half B, no gaps.
    task automatic send_frame(input int are, input int aim, input int bre, input int bim);
        for (int k = 0; k < 2*DEPTH; k++) begin
            in_valid = 1'b1;
            if (k < DEPTH) set_all(are, aim);
            else           set_all(bre, bim);
            tick();
        end
    endtask

    task automatic send_ramp();
        for (int k = 0; k < 2*DEPTH; k++) begin
            in_valid = 1'b1;
            for (int p = 0; p < NP; p++) begin
                in_real[p*LENGTH +: LENGTH] = LENGTH'(p + k);
                in_imag[p*LENGTH +: LENGTH] = LENGTH'(k - p);
            end
            tick();
        end
    endtask

    // Output beat i (relative to b): path p must be re0+rs*p / im0+is*p.
    task automatic check_beat(input string tag, input int b, input int i,
                              input int re0, input int rs, input int im0, input int is,
                              input logic lst, input logic ovf);
        if (b + i >= oq.size()) begin
            check($sformatf("%s_present[%0d]", tag, i), 0, 1);
        end else begin
            for (int p = 0; p < NP; p++) begin
                check($sformatf("%s_re[%0d].p%0d", tag, i, p), pv(oq[b+i].re, p), re0 + rs*p);
                check($sformatf("%s_im[%0d].p%0d", tag, i, p), pv(oq[b+i].im, p), im0 + is*p);
            end
            check($sformatf("%s_last[%0d]", tag, i), oq[b+i].last, lst);
`ifdef BFLY02_OVF_FLAG_EN
            check($sformatf("%s_ovf[%0d]", tag, i), oq[b+i].ovf, ovf);
`else
            if (ovf === 1'bx) check($sformatf("%s_ovf[%0d]", tag, i), 0, 1);
`endif
        end
    endtask

    initial begin
        int b, r0, j, ph;
        int acc_c[DEPTH];

        rst      = 1'b1;
        in_valid = 1'b0;
        set_all(0, 0);
        repeat (3) tick();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_real_zero", out_real == '0, 1);
        check("rst_out_imag_zero", out_imag == '0, 1);
        check("rst_in_ready", in_ready, 1);
`ifdef BFLY02_OVF_FLAG_EN
        check("rst_ovf_flag", ovf_flag, 0);
`endif
        rst = 1'b0;
        tick();

        // T1: single frame, sums 120+j40, drain of 80+j60
        b = oq.size();
        send_frame(100, 50, 20, -10);
        in_valid = 1'b0;
        r0 = rdy_low;
        repeat (25) tick();
        check("t1_count", oq.size() - b, 32);
        check("t1_drain_ready_low", rdy_low - r0, 16);
        for (int i = 0; i < DEPTH; i++) begin
            check_beat("t1_sum", b, i, 120, 0, 40, 0, 1'b0, 1'b0);
            check_beat("t1_dif", b, DEPTH + i, 80, 0, 60, 0, i == DEPTH-1, 1'b0);
        end
        if (oq.size() - b >= 32) begin
            check("t1_sum_contig", oq[b+15].cyc - oq[b].cyc, 15);
            check("t1_drain_contig", oq[b+31].cyc - oq[b+16].cyc, 15);
        end

        // T2: two frames back to back (overlap path)
        b = oq.size();
        r0 = rdy_low;
        send_frame(100, 50, 20, -10);
        send_frame(-30, 7, 5, -3);
        check("t2_ready_during_stream", rdy_low - r0, 0);
        in_valid = 1'b0;
        repeat (25) tick();
        check("t2_count", oq.size() - b, 64);
        for (int i = 0; i < DEPTH; i++) begin
            check_beat("t2_sum1", b, i, 120, 0, 40, 0, 1'b0, 1'b0);
            check_beat("t2_dif1", b, DEPTH + i, 80, 0, 60, 0, i == DEPTH-1, 1'b0);
            check_beat("t2_sum2", b, 2*DEPTH + i, -25, 0, 4, 0, 1'b0, 1'b0);
            check_beat("t2_dif2", b, 3*DEPTH + i, -35, 0, 10, 0, i == DEPTH-1, 1'b0);
        end
        if (oq.size() - b >= 64)
            check("t2_no_gap", oq[b+47].cyc - oq[b].cyc, 47);

        // T3: extreme magnitudes
        b = oq.size();
        send_frame(4095, -4096, 4095, 4095);
        in_valid = 1'b0;
        repeat (25) tick();
        check("t3_count", oq.size() - b, 32);
        for (int i = 0; i < DEPTH; i++) begin
            check_beat("t3_sum", b, i, 8190, 0, -1, 0, 1'b0, 1'b1);
            check_beat("t3_dif", b, DEPTH + i, 0, 0, -8191, 0, i == DEPTH-1, 1'b1);
        end

        // T4: gaps during CALC, valid pattern 1,0,0,1
        b = oq.size();
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1;
            set_all(10*k, -k);
            tick();
        end
        j = 0;
        ph = 0;
        while (j < DEPTH) begin
            if ((ph % 4 == 0) || (ph % 4 == 3)) begin
                in_valid = 1'b1;
                set_all(j, 2*j);
                acc_c[j] = cyc;
                j++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            ph++;
        end
        in_valid = 1'b0;
        repeat (25) tick();
        check("t4_count", oq.size() - b, 32);
        for (int i = 0; i < DEPTH; i++) begin
            check_beat("t4_sum", b, i, 11*i, 0, i, 0, 1'b0, 1'b0);
            check_beat("t4_dif", b, DEPTH + i, 9*i, 0, -3*i, 0, i == DEPTH-1, 1'b0);
            if (b + i < oq.size())
                check($sformatf("t4_latency[%0d]", i), oq[b+i].cyc, acc_c[i] + 1);
        end

        // T5: reset in the middle of CALC
        for (int k = 0; k < DEPTH + 5; k++) begin
            in_valid = 1'b1;
            set_all(7, 7);
            tick();
        end
        in_valid = 1'b0;
        check("t5_pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_last", out_last, 0);
        check("t5_async_real_zero", out_real == '0, 1);
        check("t5_async_imag_zero", out_imag == '0, 1);
        tick();
        tick();
        rst = 1'b0;
        b = oq.size();
        repeat (5) tick();
        check("t5_no_stale_output", oq.size() - b, 0);

        // T6: per-path ramp after the reset
        b = oq.size();
        send_ramp();
        in_valid = 1'b0;
        repeat (25) tick();
        check("t6_count", oq.size() - b, 32);
        for (int i = 0; i < DEPTH; i++) begin
            check_beat("t6_sum", b, i, 16 + 2*i, 2, 16 + 2*i, -2, 1'b0, 1'b0);
            check_beat("t6_dif", b, DEPTH + i, -16, 0, -16, 0, i == DEPTH-1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
